// File: rtl/sync_memory_pkg.sv
// ============================================================================
// Module      : sync_memory_pkg
// Description : Shared types and helpers for the sync_memory block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sync_memory_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  function automatic logic in_range(input logic [63:0] addr, input logic [63:0] depth);
    return addr < depth;
  endfunction

  // Index width of the storage array; a single-word memory still needs one bit.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_memory_array.sv
// ============================================================================
// Module      : sync_memory_array
// Description : Reset-free storage: one write port, one registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_memory_array #(
  parameter int DATA_WIDTH = 8,
  parameter int IDX_WIDTH  = 12,
  parameter int DEPTH      = 'h1000
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [IDX_WIDTH-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [IDX_WIDTH-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/sync_memory.sv
// ============================================================================
// Module      : sync_memory
// Description : Single-port synchronous RAM with valid/ready requests, 1-cycle
//               registered read response, range checking and an optional
//               post-reset clear sweep (enabled by SYNC_MEMORY_CLEAR_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_memory
  import sync_memory_pkg::*;
#(
  parameter int                   DATA_WIDTH  = 8,
  parameter int                   ADDR_WIDTH  = 16,
  parameter int                   DEPTH       = 'h1000,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int IDX_W = idx_width(DEPTH);

  state_t                state_q;
  logic [IDX_W-1:0]      clr_addr_q;
  logic                  accept;
  logic                  addr_ok;
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_re;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;

`ifdef SYNC_MEMORY_CLEAR_EN
  state_t           state_d;
  logic [IDX_W-1:0] clr_addr_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (state_q == ST_CLEAR) begin
      if (clr_addr_q == IDX_W'(DEPTH - 1)) begin
        state_d    = ST_IDLE;
        clr_addr_d = '0;
      end else begin
        clr_addr_d = clr_addr_q + IDX_W'(1);
      end
    end
  end
`else
  assign state_q    = ST_IDLE;
  assign clr_addr_q = '0;
`endif

  always_comb begin
    req_ready = (state_q == ST_IDLE);
    busy      = (state_q == ST_CLEAR);
    rsp_valid = rsp_valid_q;
    rsp_err   = rsp_err_q;
    rsp_rdata = (rsp_valid_q && !rsp_err_q) ? mem_rdata : '0;
  end

  // The sweep owns the write port while busy; requests are blocked then anyway.
  always_comb begin
    accept  = req_valid && req_ready;
    addr_ok = in_range(64'(req_addr), 64'(DEPTH));
    if (busy) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr_q;
      mem_wdata = CLEAR_VALUE;
    end else begin
      mem_we    = accept && req_write && addr_ok;
      mem_waddr = req_addr[IDX_W-1:0];
      mem_wdata = req_wdata;
    end
    mem_re      = accept && !req_write && addr_ok;
    rsp_valid_d = accept && !req_write;
    rsp_err_d   = accept && !req_write && !addr_ok;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  sync_memory_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_W),
    .DEPTH      (DEPTH)
  ) u_array (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_addr (mem_waddr),
    .wr_data (mem_wdata),
    .rd_en   (mem_re),
    .rd_addr (req_addr[IDX_W-1:0]),
    .rd_data (mem_rdata)
  );

endmodule

`default_nettype wire
